// File: rtl/fp8_issue_ctrl.sv
// fp8_issue_ctrl: start/done initiator that issues tagged commands to the FP8 unit and returns responses
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_op, cmd_a, cmd_b, cmd_tag carry the command
//   u_start, u_op, u_a, u_b      single-cycle start pulse and operands to the FP8 unit
//   u_done, u_result, u_flag_*   completion, result and flags from the FP8 unit
//   rsp_valid/rsp_ready          response handshake; rsp_result, rsp_flags {zero,ovf,unf,inexact},
//                                rsp_tag, rsp_timeout carry the response
//   busy                         controller is not idle
//   cnt_done, cnt_timeout        saturating counts of normal and watchdog completions
module fp8_issue_ctrl #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             u_start,
    output logic [1:0]       u_op,
    output logic [7:0]       u_a,
    output logic [7:0]       u_b,
    input  logic             u_done,
    input  logic [7:0]       u_result,
    input  logic             u_flag_zero,
    input  logic             u_flag_overflow,
    input  logic             u_flag_underflow,
    input  logic             u_flag_inexact,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [7:0]       cnt_done,
    output logic [7:0]       cnt_timeout
);
    typedef enum logic [2:0] {IDLE, ISSUE, BLANK, WAIT, RESP} state_t;

    // Watchdog value on the last WAIT cycle that may still accept a done.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] wd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            u_start     <= 1'b0;
            u_op        <= 2'b00;
            u_a         <= 8'h00;
            u_b         <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_result  <= 8'h00;
            rsp_flags   <= 4'h0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            cnt_done    <= 8'h00;
            cnt_timeout <= 8'h00;
            wd          <= 8'h00;
        end else begin
            u_start <= 1'b0;
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    u_op      <= cmd_op;
                    u_a       <= cmd_a;
                    u_b       <= cmd_b;
                    rsp_tag   <= cmd_tag;
                    u_start   <= 1'b1;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: state <= BLANK;
                // A done seen here may be left over from the previous operation, so it is dropped.
                BLANK: begin
                    wd    <= 8'h00;
                    state <= WAIT;
                end
                // Done is tested before the watchdog so a done on the final allowed cycle still wins.
                WAIT: if (u_done) begin
                    rsp_result  <= u_result;
                    rsp_flags   <= {u_flag_zero, u_flag_overflow, u_flag_underflow, u_flag_inexact};
                    rsp_timeout <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end else if (wd == WD_LAST) begin
                    rsp_result  <= 8'h00;
                    rsp_flags   <= 4'h0;
                    rsp_timeout <= 1'b1;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end else begin
                    wd <= wd + 8'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                    if (rsp_timeout) begin
                        if (cnt_timeout != 8'hFF) cnt_timeout <= cnt_timeout + 8'd1;
                    end else begin
                        if (cnt_done != 8'hFF) cnt_done <= cnt_done + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
